cic3_row_readout_sequencer: RTL and testbench

Readout scheduler for the 2x12 CIC3 filter row. On each decimated-sample strobe it walks the channel-select index across all filter outputs and captures each word from the row's external output mux. It presents the words as one frame on a valid/ready stream toward the serializer. It also tracks frame count and flags strobes that arrive while a frame is still in flight.

---
 rtl/cic3_row_readout_sequencer_if.sv | 24 ++
 rtl/cic3_row_readout_sequencer.sv | 134 +++++++++++++
 tb/tb_cic3_row_readout_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic3_row_readout_sequencer_if.sv
// Stream bundle from the CIC3 row readout sequencer to the serializer.
// The master drives words; the slave applies backpressure through out_ready.
interface cic3_row_readout_sequencer_if #(
    parameter int DATA_WIDTH = 25
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/cic3_row_readout_sequencer.sv
// CIC3 row readout: walks chan_sel over the row mux and streams one frame per strobe.
// Define CIC3_READOUT_HEADER_EN to prefix each frame with a frame-count header word.
module cic3_row_readout_sequencer #(
    parameter int NUM_CHANNELS    = 24,
    parameter int DATA_WIDTH      = 25,
    parameter int FRAME_CNT_WIDTH = 8,
    parameter int SEL_WIDTH       = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       sample_strobe,
    output logic [SEL_WIDTH-1:0]       chan_sel,
    input  logic [DATA_WIDTH-1:0]      chan_data,
    cic3_row_readout_sequencer_if.master strm,
    output logic                       busy,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic                       overrun,
    input  logic                       clr_overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PRESENT,
        HEADER
    } state_t;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_CHANNELS - 1);

    state_t                     state, state_d;
    logic [SEL_WIDTH-1:0]       idx, idx_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       last_q, last_d;
    logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                       ovr_q, ovr_d;
    logic                       accept;

    assign accept = valid_q && strm.out_ready;
    assign busy   = (state != IDLE);

    // The mux only ever sees a live index while a channel word is being fetched or held.
    assign chan_sel = (state == SETUP || state == PRESENT) ? idx : '0;

    assign strm.out_data  = data_q;
    assign strm.out_valid = valid_q;
    assign strm.out_last  = last_q;
    assign frame_cnt      = cnt_q;
    assign overrun        = ovr_q;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;

        // A strobe that lands while busy must survive a simultaneous clear.
        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        if (sample_strobe && busy) begin
            ovr_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (sample_strobe && enable) begin
                    idx_d = '0;
`ifdef CIC3_READOUT_HEADER_EN
                    state_d = HEADER;
                    data_d  = DATA_WIDTH'(cnt_q);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
`else
                    state_d = SETUP;
`endif
                end
            end
            HEADER: begin
                if (accept) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                data_d  = chan_data;
                valid_d = 1'b1;
                last_d  = (idx == LAST_IDX);
                state_d = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = SETUP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_cic3_row_readout_sequencer.sv
// Directed bench for the CIC3 row readout sequencer; the row mux returns 1000+chan_sel.
// Build with CIC3_READOUT_HEADER_EN defined to exercise the header word.
`timescale 1ns/1ps
module tb_cic3_row_readout_sequencer;

    localparam int N  = 24;
    localparam int DW = 25;
    localparam int CW = 8;
    localparam int SW = 5;
`ifdef CIC3_READOUT_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          sample_strobe = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [SW-1:0] chan_sel;
    logic [DW-1:0] chan_data;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic          overrun;

    cic3_row_readout_sequencer_if #(.DATA_WIDTH(DW)) strm ();

    cic3_row_readout_sequencer #(
        .NUM_CHANNELS(N),
        .DATA_WIDTH(DW),
        .FRAME_CNT_WIDTH(CW),
        .SEL_WIDTH(SW)
    ) u_dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .sample_strobe(sample_strobe),
        .chan_sel(chan_sel),
        .chan_data(chan_data),
        .strm(strm),
        .busy(busy),
        .frame_cnt(frame_cnt),
        .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    assign chan_data = DW'(1000) + DW'(chan_sel);

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] wq[$];
    bit            lq[$];
    int            first_c;
    int            last_c;
    int            viol;
    bit            tmo;
    logic [15:0]   lfsr = 16'hACE1;
    logic [CW-1:0] exp_cnt = '0;

    // Runs one frame: strobe at c=0, optional extra strobe/clear/disable at given cycles.
    task automatic collect(input bit rnd, input int strobe_at,
                           input int clr_at, input int dis_at);
        bit            hold = 1'b0;
        bit            done = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [SW-1:0] ps = '0;
        wq.delete();
        lq.delete();
        first_c = -1;
        last_c  = -1;
        viol    = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (hold && (!strm.out_valid || strm.out_data !== pd || chan_sel !== ps)) viol++;
            if (chan_sel > SW'(N - 1)) viol++;
            if (strm.out_valid && first_c < 0) first_c = c;
            sample_strobe = (c == 0) || (c == strobe_at);
            clr_overrun = (c == clr_at);
            if (c == dis_at) enable = 1'b0;
            if (rnd) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                strm.out_ready = lfsr[0];
            end else begin
                strm.out_ready = 1'b1;
            end
            if (strm.out_valid && strm.out_ready) begin
                wq.push_back(strm.out_data);
                lq.push_back(strm.out_last);
                if (strm.out_last) begin
                    done = 1'b1;
                    last_c = c;
                end
            end
            hold = strm.out_valid && !strm.out_ready;
            pd = strm.out_data;
            ps = chan_sel;
        end
        tmo = !done;
        @(negedge clk);
        sample_strobe = 1'b0;
        clr_overrun = 1'b0;
        strm.out_ready = 1'b1;
    endtask

    function automatic int bad_words(input logic [DW-1:0] hdr_val);
        int            b = 0;
        logic [DW-1:0] e;
        if (wq.size() != N + HDR) return 1000;
        for (int j = 0; j < N + HDR; j++) begin
            e = (HDR == 1 && j == 0) ? hdr_val : DW'(1000 + j - HDR);
            if (wq[j] !== e) b++;
            if (lq[j] !== (j == N + HDR - 1)) b++;
        end
        return b;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        strm.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({chan_sel, strm.out_data} !== '0) begin
            fails++;
            $display("FAIL reset_sel_data: got %0d/%0d want 0/0", chan_sel, strm.out_data);
        end
        tests++;
        if ({strm.out_valid, strm.out_last, busy, overrun} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags: got v%b l%b b%b o%b want all 0",
                     strm.out_valid, strm.out_last, busy, overrun);
        end
        tests++;
        if (frame_cnt !== '0) begin
            fails++;
            $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
        end
        reset_n = 1'b1;
        enable = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [CW-1:0] h = exp_cnt;
        int            nb;
        collect(1'b0, -1, -1, -1);
        exp_cnt++;
        nb = bad_words(DW'(h));
        tests++;
        if (tmo || nb !== 0) begin
            fails++;
            $display("FAIL basic_words: got %0d bad (timeout %0b) want 0", nb, tmo);
        end
        tests++;
        if (first_c !== 2 - HDR) begin
            fails++;
            $display("FAIL basic_latency: got %0d want %0d", first_c, 2 - HDR);
        end
        tests++;
        if (last_c !== 2 * N + HDR) begin
            fails++;
            $display("FAIL basic_frame_len: got %0d want %0d", last_c, 2 * N + HDR);
        end
        tests++;
        if (frame_cnt !== exp_cnt || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_cnt_busy: got %0d/%b want %0d/0", frame_cnt, busy, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] h = exp_cnt;
        int            nb;
        collect(1'b1, -1, -1, -1);
        exp_cnt++;
        nb = bad_words(DW'(h));
        tests++;
        if (tmo || nb !== 0) begin
            fails++;
            $display("FAIL bp_words: got %0d bad (timeout %0b) want 0", nb, tmo);
        end
        tests++;
        if (viol !== 0) begin
            fails++;
            $display("FAIL bp_stable: got %0d unstable cycles want 0", viol);
        end
        tests++;
        if (frame_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL bp_cnt: got %0d want %0d", frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_overrun();
        logic [CW-1:0] h = exp_cnt;
        int            nb;
        collect(1'b0, 10, -1, -1);
        exp_cnt++;
        nb = bad_words(DW'(h));
        tests++;
        if (overrun !== 1'b1 || tmo || nb !== 0) begin
            fails++;
            $display("FAIL ovr_set: got ovr %b bad %0d want ovr 1 bad 0", overrun, nb);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || frame_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL ovr_dropped: got busy %b cnt %0d want 0/%0d", busy, frame_cnt, exp_cnt);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_clear: got %b want 0", overrun);
        end
        collect(1'b0, 9, 9, -1);
        exp_cnt++;
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_set_wins: got %b want 1", overrun);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        collect(1'b0, 2 * N + HDR, -1, -1);
        exp_cnt++;
        @(negedge clk);
        tests++;
        if (overrun !== 1'b1 || busy !== 1'b0 || frame_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL ovr_final_accept: got ovr %b busy %b cnt %0d want 1/0/%0d",
                     overrun, busy, frame_cnt, exp_cnt);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
    endtask

    task automatic test_wrap_enable();
        int            tot = 0;
        int            nf = 256 - int'(exp_cnt);
        logic [CW-1:0] h;
        for (int f = 0; f < nf; f++) begin
            h = exp_cnt;
            collect(1'b0, -1, -1, -1);
            exp_cnt++;
            tot += bad_words(DW'(h)) + int'(tmo);
        end
        tests++;
        if (tot !== 0 || frame_cnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap: got %0d bad words cnt %0d want 0/0", tot, frame_cnt);
        end
        h = exp_cnt;
        collect(1'b0, -1, -1, 12 + HDR);
        exp_cnt++;
        tests++;
        if (tmo || bad_words(DW'(h)) !== 0 || frame_cnt !== 8'd1) begin
            fails++;
            $display("FAIL enable_drop_frame: got cnt %0d timeout %0b want 1/0", frame_cnt, tmo);
        end
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || overrun !== 1'b0 || strm.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL enable_ignored: got busy %b ovr %b valid %b want 0/0/0",
                     busy, overrun, strm.out_valid);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        bit found = 1'b0;
        int nb;
        @(negedge clk);
        sample_strobe = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            sample_strobe = 1'b0;
            if (strm.out_valid && strm.out_data == DW'(1012)) found = 1'b1;
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (!found || {chan_sel, strm.out_data, strm.out_valid, strm.out_last,
                       busy, frame_cnt, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_mid_frame: found %0b sel %0d data %0d v%b b%b cnt %0d want 0s",
                     found, chan_sel, strm.out_data, strm.out_valid, busy, frame_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        collect(1'b0, -1, -1, -1);
        exp_cnt++;
        nb = bad_words('0);
        tests++;
        if (tmo || nb !== 0 || frame_cnt !== 8'd1) begin
            fails++;
            $display("FAIL post_reset_frame: got %0d bad cnt %0d want 0/1", nb, frame_cnt);
        end
    endtask

`ifdef CIC3_READOUT_HEADER_EN
    task automatic test_header();
        int nb;
        while (exp_cnt != 8'd7) begin
            collect(1'b0, -1, -1, -1);
            exp_cnt++;
        end
        collect(1'b0, -1, -1, -1);
        exp_cnt++;
        nb = bad_words(DW'(7));
        tests++;
        if (wq.size() != N + 1 || wq[0] !== DW'(7)) begin
            fails++;
            $display("FAIL header_word: got size %0d want 25 with first word 7", wq.size());
        end
        tests++;
        if (nb !== 0 || frame_cnt !== 8'd8) begin
            fails++;
            $display("FAIL header_frame: got %0d bad cnt %0d want 0/8", nb, frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overrun();
        test_wrap_enable();
        test_reset_mid_frame();
`ifdef CIC3_READOUT_HEADER_EN
        test_header();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
